dev_stream_buffer: RTL

//   External-device-side ping-pong buffer directly upstream of the DMA engine.

---
 rtl/tsc_dma_pkg.sv | 17 +
 rtl/dev_stream_buffer_if.sv | 23 ++
 rtl/dev_buf_bank.sv | 27 ++
 rtl/dev_stream_buffer.sv | 99 +++++++++
 4 files changed

// File: rtl/tsc_dma_pkg.sv
// Shared constants and bank state type for the device stream buffer and the DMA engine.
package tsc_dma_pkg;
  localparam int WORD_SIZE   = 16;
  localparam int CHUNK_WORDS = 4;
  localparam int NUM_CHUNKS  = 3;
  localparam int BLOCK_WORDS = NUM_CHUNKS * CHUNK_WORDS;
  localparam int CHUNK_W     = WORD_SIZE * CHUNK_WORDS;
  localparam int IDX_W       = $clog2(BLOCK_WORDS);
  localparam int OFF_W       = 2;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {FREE, FILLING, FULL, DRAIN} bank_state_t;

  function automatic logic [IDX_W-1:0] word_addr(input logic [OFF_W-1:0] off, input int k);
    return IDX_W'(int'(off) * CHUNK_WORDS + k);
  endfunction
endpackage

// File: rtl/dev_stream_buffer_if.sv
// Stream-in and DMA-side signal bundle of the device stream buffer.
interface dev_stream_buffer_if;
  import tsc_dma_pkg::*;

  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_data;
  logic                 in_ready;
  logic [OFF_W-1:0]     offset;
  logic [CHUNK_W-1:0]   edata;
  logic                 dev_irq;
  logic                 dma_done;
  logic [CNT_W-1:0]     drop_cnt;

  modport master (
    output in_valid, in_data, offset, dma_done,
    input  in_ready, edata, dev_irq, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, offset, dma_done,
    output in_ready, edata, dev_irq, drop_cnt
  );
endinterface

// File: rtl/dev_buf_bank.sv
// One 12-word storage bank: single write port, chunk-wide read selected by the DMA offset.
module dev_buf_bank
  import tsc_dma_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [WORD_SIZE-1:0] data,
  input  logic [OFF_W-1:0]     offset,
  output logic [CHUNK_W-1:0]   chunk
);
  logic [WORD_SIZE-1:0] mem [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= data;
  end

  // Offsets past the last chunk read as zero rather than aliasing other words.
  always_comb begin
    chunk = '0;
    if (offset < OFF_W'(NUM_CHUNKS)) begin
      for (int k = 0; k < CHUNK_WORDS; k++) begin
        chunk[k*WORD_SIZE +: WORD_SIZE] = mem[word_addr(offset, k)];
      end
    end
  end
endmodule

// File: rtl/dev_stream_buffer.sv
// Ping-pong block buffer between a device word stream and the DMA engine.
// Optional drop counter built only when DEVBUF_DROP_CNT_EN is defined.
module dev_stream_buffer
  import tsc_dma_pkg::*;
(
  input logic                CLK,
  input logic                reset_n,
  dev_stream_buffer_if.slave bus
);
  bank_state_t        st [2];
  bank_state_t        st_nxt [2];
  logic [IDX_W-1:0]   wr_idx, wr_idx_nxt;
  logic               fill_bank, fill_bank_nxt;
  logic               irq, irq_nxt;
  logic               accept, last_word, drain_any;
  logic [CHUNK_W-1:0] chunk [2];

  assign bus.in_ready = (st[fill_bank] == FREE) || (st[fill_bank] == FILLING);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_word    = accept && (wr_idx == IDX_W'(BLOCK_WORDS - 1));
  assign drain_any    = (st[0] == DRAIN) || (st[1] == DRAIN);

  always_comb begin
    st_nxt        = st;
    wr_idx_nxt    = wr_idx;
    fill_bank_nxt = fill_bank;
    if (accept) begin
      wr_idx_nxt = last_word ? '0 : wr_idx + IDX_W'(1);
      if (last_word) fill_bank_nxt = ~fill_bank;
    end
    for (int b = 0; b < 2; b++) begin
      if (accept && (fill_bank == 1'(b))) st_nxt[b] = last_word ? FULL : FILLING;
      if ((st[b] == DRAIN) && bus.dma_done) st_nxt[b] = FREE;
    end
    // Promotion looks at the pre-edge state, so a freed bank always leaves one idle cycle.
    if (!drain_any) begin
      if (st[0] == FULL)      st_nxt[0] = DRAIN;
      else if (st[1] == FULL) st_nxt[1] = DRAIN;
    end
    irq_nxt = (st_nxt[0] == DRAIN) || (st_nxt[1] == DRAIN);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      st[0]     <= FREE;
      st[1]     <= FREE;
      wr_idx    <= '0;
      fill_bank <= 1'b0;
      irq       <= 1'b0;
    end else begin
      st        <= st_nxt;
      wr_idx    <= wr_idx_nxt;
      fill_bank <= fill_bank_nxt;
      irq       <= irq_nxt;
    end
  end

  assign bus.dev_irq = irq;

  dev_buf_bank u_bank0 (
    .clk    (CLK),
    .we     (accept && (fill_bank == 1'b0)),
    .idx    (wr_idx),
    .data   (bus.in_data),
    .offset (bus.offset),
    .chunk  (chunk[0])
  );

  dev_buf_bank u_bank1 (
    .clk    (CLK),
    .we     (accept && (fill_bank == 1'b1)),
    .idx    (wr_idx),
    .data   (bus.in_data),
    .offset (bus.offset),
    .chunk  (chunk[1])
  );

  always_comb begin
    bus.edata = '0;
    if (st[0] == DRAIN)      bus.edata = chunk[0];
    else if (st[1] == DRAIN) bus.edata = chunk[1];
  end

`ifdef DEVBUF_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (bus.in_valid && !bus.in_ready && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign bus.drop_cnt = drop_cnt;
`else
  assign bus.drop_cnt = '0;
`endif
endmodule
